// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit.
//   lsu_op_t      : CPU memory operation codes (loads 0..4, stores 5..7)
//   lsu_state_t   : LSU control FSM encoding
//   is_load       : op is one of LB/LBU/LH/LHU/LW
//   is_misaligned : access violates natural alignment, or op is undefined
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_RESP      = 2'd3
  } lsu_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  // Undefined op codes report as misaligned so the CPU sees an error and
  // no bus command is ever issued for them.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    logic r;
    case (op)
      LB, LBU, SB: r = 1'b0;
      LH, LHU, SH: r = a[0];
      LW, SW:      r = |a;
      default:     r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   op, addr_lo  : latched operation and low address bits
//   wdata        : right-justified store data
//   rdata        : bus read data
//   byteenable   : lane enables for the access (loads use the same enables)
//   writedata    : store data replicated across all lanes of its size
//   load_result  : selected lane, sign/zero extended per op (0 for non-loads)
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    case (op)
      LB, LBU, SB: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
      end
      LH, LHU, SH: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
      end
      default: begin
        byteenable = 4'b1111;
        writedata  = wdata;
      end
    endcase

    case (op)
      LB:      load_result = {{24{byte_lane[7]}}, byte_lane};
      LBU:     load_result = {24'b0, byte_lane};
      LH:      load_result = {{16{half_lane[15]}}, half_lane};
      LHU:     load_result = {16'b0, half_lane};
      LW:      load_result = rdata;
      default: load_result = 32'b0;
    endcase
  end

endmodule

// File: rtl/mips_lsu_avalon.sv
// Load/store unit between the MIPS datapath and an Avalon-style data port.
// One CPU request becomes at most one word-aligned bus transaction.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   req_valid/req_ready/req_op/
//   req_addr/req_wdata           : CPU request channel
//   rsp_valid/rsp_rdata/rsp_err  : one-cycle completion pulse and result
//   address/byteenable/read/
//   write/writedata/waitrequest/
//   readdata                     : Avalon-style memory master port
//   state_dbg                    : current FSM state (lsu_state_t encoding)
//
// Handshakes: the CPU request is accepted at a clk edge where
// req_valid & req_ready (req_ready is high only in IDLE). A bus command is
// accepted at a clk edge where (read|write) & !waitrequest; until then the
// command, address, byteenable and writedata are held unchanged. rsp_valid
// is a single-cycle pulse with no back-pressure.
module mips_lsu_avalon
  import mips_lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] CMD       = ST_CMD;
  localparam logic [1:0] WAIT_DATA = ST_WAIT_DATA;
  localparam logic [1:0] RESP      = ST_RESP;
  localparam logic [1:0] CNT_INIT  = 2'(READ_LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt;

  logic [3:0]  be_w;
  logic [31:0] wd_w;
  logic [31:0] ld_w;

  lsu_lane_align u_align (
    .op          (op_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (readdata),
    .byteenable  (be_w),
    .writedata   (wd_w),
    .load_result (ld_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              rsp_err <= 1'b1;
              state   <= RESP;
            end else begin
              rsp_err <= 1'b0;
              state   <= CMD;
            end
          end
        end
        CMD: begin
          if (!waitrequest) begin
            if (is_load(op_q)) begin
              cnt   <= CNT_INIT;
              state <= WAIT_DATA;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT_DATA: begin
          // cnt == 0 marks the edge at which readdata is valid
          if (cnt == 2'd0) begin
            rsp_rdata <= ld_w;
            state     <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs come straight from registered state; they are forced to
  // zero outside CMD so the port is quiet between transactions.
  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    read       = (state == CMD) &&  is_load(op_q);
    write      = (state == CMD) && !is_load(op_q);
    address    = (state == CMD) ? {addr_q[31:2], 2'b00} : 32'b0;
    byteenable = (state == CMD) ? be_w : 4'b0;
    writedata  = (state == CMD) ? wd_w : 32'b0;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_mips_lsu_avalon.sv
// Scoreboard bench for mips_lsu_avalon. Lane 0 runs READ_LATENCY=1,
// lane 1 runs READ_LATENCY=3. Each lane has a bus slave model and a
// monitor that pops expected responses from its exp_q.
`timescale 1ns/1ps
module tb_mips_lsu_avalon;
  import mips_lsu_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [7:0]  ncmd;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        reset_n   [2];
  logic        req_valid [2];
  logic [3:0]  req_op    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  int          cfg_stalls[2];
  logic [31:0] cfg_rdata [2];

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] address   [2];
  logic [3:0]  byteenable[2];
  logic        read      [2];
  logic        write     [2];
  logic [31:0] writedata [2];
  logic [1:0]  state_dbg [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at cyc %0d", name, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int RL = (g == 0) ? 1 : 3;
    exp_t        exp_q[$];
    exp_t        e;
    int          cmd_cnt = 0;
    bit          in_cmd  = 0;
    int          left    = 0;
    int          due     = -1;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata    = 32'hDEADBEEF;

    mips_lsu_avalon #(.READ_LATENCY(RL)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_op      (req_op[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_err     (rsp_err[g]),
      .address     (address[g]),
      .byteenable  (byteenable[g]),
      .read        (read[g]),
      .write       (write[g]),
      .writedata   (writedata[g]),
      .waitrequest (waitrequest),
      .readdata    (readdata),
      .state_dbg   (state_dbg[g])
    );

    // bus slave: stall each command cfg_stalls cycles, return data exactly
    // RL edges after read acceptance, junk otherwise
    always @(negedge clk) begin
      if (read[g] || write[g]) begin
        if (!in_cmd) begin
          in_cmd = 1;
          left   = cfg_stalls[g];
        end
        if (left > 0) begin
          waitrequest = 1'b1;
          left--;
        end else begin
          waitrequest = 1'b0;
          in_cmd      = 0;
          if (read[g]) due = cyc + 1 + RL;
        end
      end else begin
        waitrequest = 1'b0;
        in_cmd      = 0;
      end
      readdata = (cyc + 1 == due) ? cfg_rdata[g] : 32'hDEADBEEF;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
      if (reset_n[g]) begin
        if (read[g] || write[g]) begin
          if (exp_q.size() == 0) begin
            flag($sformatf("L%0d unexpected_cmd", g));
          end else begin
            chk($sformatf("L%0d cmd_rdwr", g), {30'b0, read[g], write[g]},
                {30'b0, exp_q[0].rd, exp_q[0].wr});
            chk($sformatf("L%0d address", g), address[g], exp_q[0].addr);
            chk($sformatf("L%0d byteenable", g), {28'b0, byteenable[g]}, {28'b0, exp_q[0].be});
            if (exp_q[0].wr)
              chk($sformatf("L%0d writedata", g), writedata[g], exp_q[0].wd);
            cmd_cnt++;
          end
        end else if (exp_q.size() == 0) begin
          cmd_cnt = 0;
        end
        if (rsp_valid[g]) begin
          if (exp_q.size() == 0) begin
            flag($sformatf("L%0d unexpected_rsp", g));
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("L%0d rsp_rdata", g), rsp_rdata[g], e.rdata);
            chk($sformatf("L%0d rsp_err", g), {31'b0, rsp_err[g]}, {31'b0, e.err});
            chk($sformatf("L%0d rsp_cycle", g), 32'(cyc), e.cyc);
            chk($sformatf("L%0d cmd_cycles", g), 32'(cmd_cnt), {24'b0, e.ncmd});
            cmd_cnt = 0;
          end
        end
      end
    end
  end

  // driver: e_lat is the cycle (1 = cycle after acceptance) of rsp_valid
  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] bus_rdata,
                       input int stalls, input logic [3:0] e_be, input logic [31:0] e_wd,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      flag($sformatf("L%0d req_ready_timeout", d));
      return;
    end
    cfg_stalls[d] = stalls;
    cfg_rdata[d]  = bus_rdata;
    req_op[d]     = op;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = e_be;
    e.wd    = e_wd;
    e.rd    = !e_err && (op <= 4'd4);
    e.wr    = !e_err && (op > 4'd4);
    e.ncmd  = e_err ? 8'd0 : 8'(stalls + 1);
    e.rdata = e_rdata;
    e.err   = e_err;
    e.cyc   = 32'(cyc + e_lat - 1);
    if (d == 0) g_lane[0].exp_q.push_back(e);
    else        g_lane[1].exp_q.push_back(e);
  endtask

  task automatic check_idle(input int d, input string tag);
    chk($sformatf("L%0d %s req_ready", d, tag), {31'b0, req_ready[d]}, 32'd1);
    chk($sformatf("L%0d %s read", d, tag), {31'b0, read[d]}, 32'd0);
    chk($sformatf("L%0d %s write", d, tag), {31'b0, write[d]}, 32'd0);
    chk($sformatf("L%0d %s rsp_valid", d, tag), {31'b0, rsp_valid[d]}, 32'd0);
    chk($sformatf("L%0d %s state", d, tag), {30'b0, state_dbg[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      reset_n[d]    = 1'b0;
      req_valid[d]  = 1'b0;
      req_op[d]     = 4'd0;
      req_addr[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
      cfg_stalls[d] = 0;
      cfg_rdata[d]  = 32'd0;
    end
    repeat (3) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check_idle(d, "reset");
      chk($sformatf("L%0d reset rsp_rdata", d), rsp_rdata[d], 32'd0);
      chk($sformatf("L%0d reset rsp_err", d), {31'b0, rsp_err[d]}, 32'd0);
      chk($sformatf("L%0d reset address", d), address[d], 32'd0);
      chk($sformatf("L%0d reset byteenable", d), {28'b0, byteenable[d]}, 32'd0);
      chk($sformatf("L%0d reset writedata", d), writedata[d], 32'd0);
    end
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    // lane 0, READ_LATENCY=1
    //     d  op   addr          wdata         bus_rdata     st be       wd            rdata         err lat
    issue(0, LW,  32'hBFC00008, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678, 0, 3);
    issue(0, LB,  32'hBFC00003, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 3);
    issue(0, LBU, 32'hBFC00003, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h0,        32'h00000080, 0, 3);
    issue(0, SH,  32'hBFC00006, 32'h0000BEEF, 32'h0,        3, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 5);
    issue(0, LH,  32'hBFC00001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue(0, SB,  32'h00000002, 32'h123456A7, 32'h0,        1, 4'b0100, 32'hA7A7A7A7, 32'h0,        0, 3);
    issue(0, SW,  32'h00000010, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 2);
    issue(0, LH,  32'h00000002, 32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0, 3);
    issue(0, LW,  32'h00000004, 32'h0,        32'hFEDCBA98, 2, 4'b1111, 32'h0,        32'hFEDCBA98, 0, 5);
    issue(0, LW,  32'h00000006, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue(0, 4'd9, 32'h00000000, 32'h0,       32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue(0, LB,  32'h00000001, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F, 0, 3);
    issue(0, LHU, 32'h00000000, 32'h0,        32'h1234F00F, 0, 4'b0011, 32'h0,        32'h0000F00F, 0, 3);

    // lane 1, READ_LATENCY=3
    issue(1, LHU, 32'hBFC00002, 32'h0,        32'hA5A50000, 0, 4'b1100, 32'h0,        32'h0000A5A5, 0, 5);
    issue(1, LW,  32'h00000000, 32'h0,        32'h11112222, 1, 4'b1111, 32'h0,        32'h11112222, 0, 6);

    // reset while lane 1 sits in WAIT_DATA
    issue(1, LW,  32'h00000040, 32'h0,        32'h55555555, 0, 4'b1111, 32'h0,        32'h55555555, 0, 5);
    @(negedge clk);
    @(negedge clk);
    reset_n[1] = 1'b0;
    #1;
    check_idle(1, "midreset");
    g_lane[1].exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    issue(1, LW,  32'h00000020, 32'h0,        32'h0BADF00D, 0, 4'b1111, 32'h0,        32'h0BADF00D, 0, 5);

    n = 0;
    while ((g_lane[0].exp_q.size() != 0 || g_lane[1].exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (g_lane[0].exp_q.size() != 0 || g_lane[1].exp_q.size() != 0)
      flag("drain_timeout");
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_lsu_avalon.md
Name: mips_lsu_avalon

Overview:
Load/store unit sitting between the MIPS datapath and the Avalon-style data memory port. It turns one CPU memory request (LB/LBU/LH/LHU/LW/SB/SH/SW) into a single word-aligned bus transaction with the correct byteenable and replicated write data. It holds read/write through waitrequest stalls and waits the fixed read latency. For loads it extracts, sign- or zero-extends and returns the result, then signals completion to the CPU control FSM.

Parameters:
READ_LATENCY, 1, cycles from read acceptance (read=1 and waitrequest=0 at a clk edge) to readdata valid; legal range 1..4.

Ports:
clk  input  1  system clock, all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  CPU presents a request
req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready at a clk edge
req_op  input  4  operation code from shared package: LB, LBU, LH, LHU, LW, SB, SH, SW
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load result; 0 for stores and errors
rsp_err  output  1  misaligned access, qualified by rsp_valid
address  output  32  bus word address, {req_addr[31:2],2'b00}
byteenable  output  4  byteenable[i] covers bus bits [8i+7:8i]
read  output  1  bus read command
write  output  1  bus write command
writedata  output  32  bus write data
waitrequest  input  1  slave stall; command must be held while high
readdata  input  32  bus read data

Behaviour:
- Reset (async, immediate): state=IDLE. req_ready=1. rsp_valid, rsp_err, read, write=0. rsp_rdata, address, byteenable, writedata=0. An in-flight transaction is abandoned; later readdata is ignored.
- States: IDLE -> CMD -> (read: WAIT_DATA) -> RESP -> IDLE.
- IDLE:
  - On acceptance, latch op, addr and wdata.
  - Misaligned request (halfword with addr[0]=1, word with addr[1:0]!=0): go to RESP with err=1; no bus command is ever issued.
- CMD:
  - Drive read or write, plus address, byteenable and writedata, all from registers.
  - Hold them stable while waitrequest=1.
  - At the edge where waitrequest=0: a write goes to RESP; a read goes to WAIT_DATA with a down-counter loaded to READ_LATENCY-1.
- WAIT_DATA:
  - read/write=0.
  - When the counter is 0, capture readdata, compute the result and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency with READ_LATENCY=1 and no stalls, request accepted at edge 0:
  - Load: read high in cycle 1; data captured at edge 2; rsp_valid in cycle 3.
  - Store: write high in cycle 1; rsp_valid in cycle 2.
  - Misaligned: rsp_valid in cycle 1.
  - Each waitrequest cycle adds exactly one cycle.
- Byteenable generation:
  - Byte: 4'b0001 << addr[1:0].
  - Halfword: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - Loads use the same enables as stores.
- Writedata generation: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extraction:
  - Byte lane = readdata[8*a+7:8*a], with a = addr[1:0].
  - Halfword lane = readdata[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Undefined req_op: treated as misaligned (rsp_err=1).
- req_valid outside IDLE is ignored (req_ready=0).

Decomposition:
- Package mips_lsu_pkg: lsu_op_t enum (LB=0, LBU, LH, LHU, LW, SB, SH, SW), lsu_state_t enum, functions is_load and is_misaligned.
- Sub-module lsu_lane_align (combinational) produces byteenable and writedata from op, addr[1:0] and wdata, and the extended load result from op, addr[1:0] and readdata.
- The top level holds only the FSM, the latency counter and the registers.

Test Plan:
- LW at 0xBFC00008, readdata=0x12345678, no stalls -> address=0xBFC00008, byteenable=4'b1111, read high 1 cycle, rsp_valid in cycle 3, rsp_rdata=0x12345678.
- LB at 0xBFC00003 then LBU at 0xBFC00003, readdata=0x80FF0000 -> byteenable=4'b1000; rsp_rdata=0xFFFFFF80, then 0x00000080.
- SH at 0xBFC00006, wdata=0x0000BEEF, waitrequest high for 3 cycles -> write, address=0xBFC00004, byteenable=4'b1100 and writedata=0xBEEFBEEF held stable for 4 cycles; rsp_valid in cycle 5.
- LH at 0xBFC00001 -> no read/write asserted, rsp_valid in cycle 1 with rsp_err=1, rsp_rdata=0.
- READ_LATENCY=3, LHU at 0xBFC00002, readdata=0xA5A50000 valid 3 cycles after acceptance -> rsp_rdata=0x0000A5A5, rsp_valid in cycle 5.
- reset_n pulsed low while in WAIT_DATA -> read=0 and req_ready=1 immediately, no rsp_valid, next LW completes normally.
